// File: rtl/plot_pkg.sv
// Shared types and defaults for the rectangle plotter.
// RECT_PLOTTER_CLEAR_EN adds the CLEAR state to the state encoding.
package plot_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_DONE  = 2'd2
`ifdef RECT_PLOTTER_CLEAR_EN
        ,
        ST_CLEAR = 2'd3
`endif
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0 .. max(a,b)-1, never narrower than one bit.
    function automatic int cnt_w(input int a, input int b);
        int m;
        m = max_int(a, b);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Nested row-major i_x/i_y counter with runtime limits, enable and synchronous init.
// last is high while both counters sit on their limits.
module scan_counter #(
    parameter int CX_W = 8,
    parameter int CY_W = 7
) (
    input  logic            clock,
    input  logic            resetN,
    input  logic            init,
    input  logic            en,
    input  logic [CX_W-1:0] lim_x,
    input  logic [CY_W-1:0] lim_y,
    output logic [CX_W-1:0] i_x,
    output logic [CY_W-1:0] i_y,
    output logic            last
);

    logic [CX_W-1:0] i_x_q, i_x_d;
    logic [CY_W-1:0] i_y_q, i_y_d;
    logic            x_at_lim, y_at_lim;

    assign x_at_lim = (i_x_q == lim_x);
    assign y_at_lim = (i_y_q == lim_y);

    always_comb begin
        i_x_d = i_x_q;
        i_y_d = i_y_q;
        if (init) begin
            i_x_d = '0;
            i_y_d = '0;
        end else if (en) begin
            if (x_at_lim) begin
                i_x_d = '0;
                i_y_d = y_at_lim ? '0 : i_y_q + CY_W'(1);
            end else begin
                i_x_d = i_x_q + CX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            i_x_q <= '0;
            i_y_q <= '0;
        end else begin
            i_x_q <= i_x_d;
            i_y_q <= i_y_d;
        end
    end

    assign i_x  = i_x_q;
    assign i_y  = i_y_q;
    assign last = x_at_lim && y_at_lim;

endmodule

// File: rtl/rect_plotter.sv
// Rectangle plotter: one pixel write per cycle over a BOX_W x BOX_H box, clipped to the screen.
// Optional screen clear (port clear, state CLEAR) is built with RECT_PLOTTER_CLEAR_EN.
module rect_plotter
    import plot_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
`ifdef RECT_PLOTTER_CLEAR_EN
    input  logic                clear,
`endif
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int CX_W = cnt_w(BOX_W, SCREEN_W);
    localparam int CY_W = cnt_w(BOX_H, SCREEN_H);

    localparam logic [CX_W-1:0] BOX_LIM_X = CX_W'(BOX_W - 1);
    localparam logic [CY_W-1:0] BOX_LIM_Y = CY_W'(BOX_H - 1);
`ifdef RECT_PLOTTER_CLEAR_EN
    localparam logic [CX_W-1:0] SCR_LIM_X = CX_W'(SCREEN_W - 1);
    localparam logic [CY_W-1:0] SCR_LIM_Y = CY_W'(SCREEN_H - 1);
`endif
    localparam logic [X_W:0] SCR_X_END = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_Y_END = (Y_W + 1)'(SCREEN_H);

    state_e                state_q, state_d;
    logic [X_W-1:0]        x_base_q, x_base_d;
    logic [Y_W-1:0]        y_base_q, y_base_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;

    logic                  cnt_init, cnt_en, cnt_last;
    logic [CX_W-1:0]       lim_x, i_x;
    logic [CY_W-1:0]       lim_y, i_y;
    logic [X_W:0]          x_wide;
    logic [Y_W:0]          y_wide;
    logic                  on_screen;

    scan_counter #(
        .CX_W (CX_W),
        .CY_W (CY_W)
    ) u_scan (
        .clock  (clock),
        .resetN (resetN),
        .init   (cnt_init),
        .en     (cnt_en),
        .lim_x  (lim_x),
        .lim_y  (lim_y),
        .i_x    (i_x),
        .i_y    (i_y),
        .last   (cnt_last)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            x_base_q <= '0;
            y_base_q <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            x_base_q <= x_base_d;
            y_base_q <= y_base_d;
            colour_q <= colour_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_base_d = x_base_q;
        y_base_d = y_base_q;
        colour_d = colour_q;
        cnt_init = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef RECT_PLOTTER_CLEAR_EN
                if (clear) begin
                    state_d  = ST_CLEAR;
                    x_base_d = '0;
                    y_base_d = '0;
                    colour_d = '0;
                    cnt_init = 1'b1;
                end else
`endif
                if (start_valid) begin
                    state_d  = ST_DRAW;
                    x_base_d = x_in;
                    y_base_d = y_in;
                    colour_d = colour_in;
                    cnt_init = 1'b1;
                end
            end
            ST_DRAW: if (cnt_last) state_d = ST_DONE;
`ifdef RECT_PLOTTER_CLEAR_EN
            ST_CLEAR: if (cnt_last) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The wide sums keep the carry so coordinates wrapping past 2^W still clip.
    assign x_wide    = {1'b0, x_base_q} + (X_W + 1)'(i_x);
    assign y_wide    = {1'b0, y_base_q} + (Y_W + 1)'(i_y);
    assign on_screen = (x_wide < SCR_X_END) && (y_wide < SCR_Y_END);

    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        plot        = 1'b0;
        cnt_en      = 1'b0;
        lim_x       = BOX_LIM_X;
        lim_y       = BOX_LIM_Y;
        x_out       = x_wide[X_W-1:0];
        y_out       = y_wide[Y_W-1:0];
        colour_out  = colour_q;
        case (state_q)
            ST_IDLE: begin
                busy        = 1'b0;
`ifdef RECT_PLOTTER_CLEAR_EN
                start_ready = !clear;
`else
                start_ready = 1'b1;
`endif
            end
            ST_DRAW: begin
                plot   = on_screen;
                cnt_en = 1'b1;
            end
`ifdef RECT_PLOTTER_CLEAR_EN
            ST_CLEAR: begin
                plot   = on_screen;
                cnt_en = 1'b1;
                lim_x  = SCR_LIM_X;
                lim_y  = SCR_LIM_Y;
            end
`endif
            ST_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: doc/rect_plotter.md
# rect_plotter

- Parametrised rectangle plotter for the VGA framebuffer path.
- Accepts a base coordinate and colour through a valid/ready handshake, then emits one pixel write per cycle in row-major order, scanning a BOX_W × BOX_H rectangle.
- Pixels off-screen are clipped; a one-cycle `done` pulse marks completion.
- Sits between the user-input/control logic and the VGA adapter's x/y/colour/plot write port.

## Interface
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- COLOUR_W, 3: colour width.
- BOX_W, 4: rectangle width in pixels (1..SCREEN_W).
- BOX_H, 4: rectangle height in pixels (1..SCREEN_H).
- SCREEN_W, 160: visible width; columns ≥ SCREEN_W are clipped.
- SCREEN_H, 120: visible height; rows ≥ SCREEN_H are clipped.

Ports:
- clock  in  1  system clock
- resetN  in  1  reset, synchronous, active-low
- start_valid  in  1  request to draw a rectangle
- start_ready  out  1  high only in IDLE; transfer occurs when start_valid && start_ready at a rising edge
- x_in  in  X_W  base x, sampled on transfer
- y_in  in  Y_W  base y, sampled on transfer
- colour_in  in  COLOUR_W  fill colour, sampled on transfer
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour_out  out  COLOUR_W  pixel colour
- plot  out  1  write strobe for the current x_out/y_out/colour_out
- busy  out  1  high in DRAW, DONE and CLEAR
- done  out  1  one-cycle pulse at end of a scan

## Operation
- **States:** IDLE, DRAW, DONE, and CLEAR (present only with CLEAR_EN).
- **IDLE:** start_ready=1, plot=0.
  - On transfer: latch x_base, y_base and colour; zero i_x and i_y; next state DRAW.
- **DRAW:**
  - x_out = x_base + i_x, y_out = y_base + i_y.
  - Each cycle i_x increments.
  - When i_x = BOX_W-1, i_x wraps to 0 and i_y increments.
  - When i_x = BOX_W-1 and i_y = BOX_H-1, next state is DONE.
- **DONE:** done=1, plot=0; next state IDLE unconditionally.
- **Clipping:**
  - Sums are computed one bit wider than the coordinate.
  - plot=0 for any cycle where the wide x sum ≥ SCREEN_W or the wide y sum ≥ SCREEN_H.
  - x_out/y_out carry the truncated sum on those cycles.
  - The scan still runs its full length, so cycle count is independent of position.
- **Ignored inputs:** start_valid while busy is ignored (no queuing); x_in, y_in and colour_in are don't-care outside the transfer cycle.
- **Reset:** resetN low at an edge takes effect from any state, mid-scan included. It forces:
  - state=IDLE;
  - x_base, y_base, colour, i_x, i_y = 0.
- **Values after the reset edge:** x_out=0, y_out=0, colour_out=0, plot=0, done=0, busy=0, start_ready=1.
- **Outputs in IDLE:** x_out/y_out/colour_out show x_base/y_base/colour with zero offsets.

## Timing
- All outputs decode combinationally from registered state, base and counter values.
- For a transfer at edge N:
  - plot cycles run over [N+1, N+BOX_W·BOX_H];
  - done is high during cycle N+BOX_W·BOX_H+1;
  - start_ready returns at N+BOX_W·BOX_H+2.
- Minimum spacing between transfers: BOX_W·BOX_H+2 cycles.
- Scan counters are sized clog2(max(BOX_W, SCREEN_W)) and clog2(max(BOX_H, SCREEN_H)).

## Configuration
- Macro: RECT_PLOTTER_CLEAR_EN.
- **Defined:**
  - Adds input port `clear` (1 bit) and state CLEAR.
  - In IDLE, `clear` has priority over start_valid; start_ready deasserts in any cycle where `clear` is high.
  - Accepting a clear loads base=(0,0) and colour=0, then scans SCREEN_W × SCREEN_H row-major with plot=1 every cycle.
  - The scan ends through DONE exactly as DRAW does.
  - Total: SCREEN_W·SCREEN_H plot cycles plus the DONE cycle.
- **Undefined:** no `clear` port and no CLEAR state; the state encoding omits it.

## Structure
- Package `plot_pkg`:
  - state enum (IDLE, DRAW, DONE, CLEAR);
  - default screen dimensions 160/120;
  - default X_W/Y_W/COLOUR_W.
- Sub-module `scan_counter`:
  - nested i_x/i_y counter with runtime limits (BOX or SCREEN), enable and synchronous init;
  - `last` output when both counters are at their limits;
  - used for both DRAW and CLEAR.

## Test plan
- Reset, then start x=10, y=20, colour=5 with defaults:
  - exactly 16 plot cycles, in order (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23);
  - colour_out=5 throughout; done one cycle later; start_ready returns the cycle after that.
- Start x=158, y=118: only the 4 pixels (158..159, 118..119) have plot=1; the scan still takes 16 cycles and ends with done.
- Start x=254, BOX_W=4: the x sum wraps past 255; all columns ≥160 are clipped and plot=0 for every cycle.
- start_valid held high through a scan: exactly one transfer per IDLE visit; new x_in values presented mid-scan do not change x_out.
- resetN low at the 7th plot cycle: next cycle plot=0, busy=0, start_ready=1, x_out=0, and no done pulse.
- With RECT_PLOTTER_CLEAR_EN, clear and start_valid asserted together:
  - the clear wins and 19200 plot cycles follow with colour_out=0, ending at (159,119);
  - then done, then IDLE.
